lsu_sbuf: RTL and testbench
===========================

// Module: lsu_sbuf
//
// PURPOSE
// Parametrised load-store unit with a posted-store buffer, sub-word access and bus watchdog.
// Sits between the core's memory stage and a single Wishbone classic master port.
// Stores retire into a FIFO and drain in order in the background.
// Loads wait until the buffer is empty, so program order is preserved.
// Byte/half/word accesses are aligned onto lanes; load data is sign/zero-extended.
//
// PARAMETERS
// ADDR_W    32   byte-address width
// SB_DEPTH  4    store buffer entries; power of 2, >= 2
// TIMEOUT   255  max cycles waiting for ack/err before abort; 0 disables watchdog
//
// PORTS
// clk          in   1       clock
// rst_i        in   1       synchronous active-high reset
// req_i        in   1       request valid
// we_i         in   1       1=store, 0=load
// size_i       in   2       00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
// unsigned_i   in   1       load zero-extend (1) / sign-extend (0)
// addr_i       in   ADDR_W  byte address
// data_i       in   32      store data, right-aligned
// ready_o      out  1       request accepted when req_i & ready_o
// valid_o      out  1       one-cycle completion pulse (load data / store posted)
// data_o       out  32      extended load data; valid with valid_o
// err_o        out  1       with valid_o: misaligned, or load bus error/timeout
// store_err_o  out  1       one-cycle pulse: buffered store got wb_err_i or timed out
// sb_empty_o   out  1       store buffer empty and no store on bus
// wb_adr_o     out  ADDR_W  word-aligned address ([1:0]=0)
// wb_dat_o     out  32      write data, lane-replicated
// wb_sel_o     out  4       byte lane select
// wb_we_o      out  1       write enable
// wb_cyc_o     out  1       cycle
// wb_stb_o     out  1       strobe
// wb_dat_i     in   32      read data
// wb_ack_i     in   1       acknowledge
// wb_err_i     in   1       bus error
//
// BEHAVIOUR
// - Reset (rst_i=1 at edge): FSM->IDLE, buffer flushed, watchdog cleared.
//   All registered outputs 0; sb_empty_o=1; ready_o=0 while rst_i high.
// - Reset mid-transfer: cyc/stb drop the next cycle; any pending completion is dropped.
// - Alignment: half needs addr[0]=0; word needs addr[1:0]=0; size 11 always misaligned.
//   A misaligned request is accepted and starts no bus cycle; valid_o=1, err_o=1, data_o=0 next cycle.
// - sel: byte = 1<<addr[1:0]; half = 0011<<addr[1]*2; word = 1111.
//   wb_dat_o: byte replicated x4, half x2.
// - ready_o (combinational):
//   - store: count<SB_DEPTH and FSM not in LD_BUS/LD_DONE;
//   - load: FSM==IDLE and count==0.
// - Store path:
//   - accepted at T: pushed into the buffer; valid_o=1, err_o=0 at T+1;
//   - a full buffer stalls (ready_o=0);
//   - push and pop in the same cycle leave count unchanged and are allowed at full.
// - FSM states and transitions:
//   - IDLE: count>0 -> ST_BUS (head driven); else accepted aligned load -> LD_BUS.
//   - ST_BUS: cyc=stb=we=1.
//     - ack: pop, -> IDLE.
//     - err/timeout: pop, store_err_o pulse, -> IDLE; draining continues.
//   - LD_BUS: cyc=stb=1, we=0.
//     - ack: latch extended lane data, -> LD_DONE.
//     - err/timeout: latch err, -> LD_DONE.
//   - LD_DONE: valid_o=1 (err_o per latch, data_o=0 on err), -> IDLE.
//   - cyc/stb are registered; they go low the cycle after ack/err.
//   - At least one IDLE cycle separates bus cycles.
// - Load latency: accepted at T -> stb at T+1 -> ack at T+1+W -> valid_o at T+3+W.
// - Watchdog:
//   - counts cycles with stb high and no ack/err, reset on each new cycle;
//   - reaching TIMEOUT aborts as err.
//   - ack and err together: ack wins.
// - Pointers wrap modulo SB_DEPTH; count width is clog2(SB_DEPTH)+1.
// - req_i held without ready_o: no side effects; inputs need not be stable.
//
// TESTING
// - Store byte 0xA5 @0x1003, ack W=0 -> valid_o at T+1; bus sel=1000, dat=A5A5A5A5, adr=0x1000.
// - Load half @0x2002 unsigned=0, wb_dat_i=0x8001_1234, ack W=2 -> valid_o at T+5, data_o=0xFFFF8001.
// - 5 stores back-to-back with SB_DEPTH=4, slave never acks -> ready_o low on 5th until first ack.
//   Drain order matches issue order.
// - Store then load, back-to-back -> load ready_o=0 until sb_empty_o=1; store hits the bus before the load.
// - Word load @0x0006 -> no cyc; valid_o=1, err_o=1, data_o=0 next cycle.
// - Load with TIMEOUT=8, no ack -> stb drops after 8 cycles, valid_o+err_o.
//   rst_i asserted mid-store -> cyc=0 next cycle, sb_empty_o=1.

Source files
------------

// File: rtl/lsu_sbuf_if.sv
// Core-side request/response and Wishbone classic signals of the load-store unit.
// Names are from the unit's point of view: i_* flow into lsu_sbuf, o_* flow out of it.
interface lsu_sbuf_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_data;
  logic              o_ready;
  logic              o_valid;
  logic [31:0]       o_data;
  logic              o_err;
  logic              o_store_err;
  logic              o_sb_empty;
  logic [ADDR_W-1:0] o_wb_adr;
  logic [31:0]       o_wb_dat;
  logic [3:0]        o_wb_sel;
  logic              o_wb_we;
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic [31:0]       i_wb_dat;
  logic              i_wb_ack;
  logic              i_wb_err;

  modport slave (
    input  i_req, i_we, i_size, i_unsigned, i_addr, i_data, i_wb_dat, i_wb_ack, i_wb_err,
    output o_ready, o_valid, o_data, o_err, o_store_err, o_sb_empty,
           o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
  );

  modport master (
    output i_req, i_we, i_size, i_unsigned, i_addr, i_data, i_wb_dat, i_wb_ack, i_wb_err,
    input  o_ready, o_valid, o_data, o_err, o_store_err, o_sb_empty,
           o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
  );
endinterface

// File: rtl/lsu_sbuf.sv
// Load-store unit with posted-store FIFO, lane alignment, load extension and bus watchdog.
// state     | meaning
// S_IDLE    | no bus cycle; drains the buffer head or launches an accepted load
// S_ST_BUS  | buffered store on the bus
// S_LD_BUS  | load on the bus
// S_LD_DONE | load finished; completion reported next cycle
module lsu_sbuf #(
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4,
  parameter int TIMEOUT  = 255
) (
  input logic       clk,
  input logic       rst_i,
  lsu_sbuf_if.slave bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_INIT = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_ST_BUS, S_LD_BUS, S_LD_DONE} state_t;
  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_sb_adr [SB_DEPTH];
  logic [31:0]       r_sb_dat [SB_DEPTH];
  logic [3:0]        r_sb_sel [SB_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              r_cyc, r_stb, r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_dat;
  logic [3:0]        r_sel;
  logic [WD_W-1:0]   r_wdog;
  logic [1:0]        r_ld_size, r_ld_off;
  logic              r_ld_uns, r_ld_err;
  logic [31:0]       r_ld_data;
  logic              r_valid, r_err, r_store_err;
  logic [31:0]       r_data;

  logic        w_misalign, w_timeout, w_done, w_pop, w_push, w_ld_go, w_acc;
  logic        w_rdy_st, w_rdy_ld, w_ready;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat, w_ld_sh, w_ld_ext;

  always_comb begin
    w_misalign = 1'b0;
    w_sel      = 4'b1111;
    w_wdat     = bus.i_data;
    case (bus.i_size)
      2'b00: begin
        w_sel  = 4'b0001 << bus.i_addr[1:0];
        w_wdat = {4{bus.i_data[7:0]}};
      end
      2'b01: begin
        w_misalign = bus.i_addr[0];
        w_sel      = 4'b0011 << {bus.i_addr[1], 1'b0};
        w_wdat     = {2{bus.i_data[15:0]}};
      end
      2'b10:   w_misalign = (bus.i_addr[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_timeout = WD_EN && (r_wdog == '0) && !bus.i_wb_ack && !bus.i_wb_err;
  assign w_done    = r_stb && (bus.i_wb_ack || bus.i_wb_err || w_timeout);
  assign w_pop     = (r_state == S_ST_BUS) && w_done;

  // A pop in flight frees a slot, so a full buffer still accepts a store that cycle.
  assign w_rdy_st = ((r_count < CW'(SB_DEPTH)) || w_pop) &&
                    (r_state != S_LD_BUS) && (r_state != S_LD_DONE);
  assign w_rdy_ld = (r_state == S_IDLE) && (r_count == '0);
  assign w_ready  = !rst_i && (bus.i_we ? w_rdy_st : w_rdy_ld);
  assign w_acc    = bus.i_req && w_ready;
  assign w_push   = w_acc && bus.i_we && !w_misalign;
  assign w_ld_go  = w_acc && !bus.i_we && !w_misalign;

  always_comb begin
    w_ld_sh = bus.i_wb_dat >> {r_ld_off, 3'b000};
    case (r_ld_size)
      2'b00:   w_ld_ext = r_ld_uns ? {24'h0, w_ld_sh[7:0]} : {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
      2'b01:   w_ld_ext = r_ld_uns ? {16'h0, w_ld_sh[15:0]} : {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
      default: w_ld_ext = w_ld_sh;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_next = S_ST_BUS;
        else if (w_ld_go)  w_next = S_LD_BUS;
      end
      S_ST_BUS: if (w_done) w_next = S_IDLE;
      S_LD_BUS: if (w_done) w_next = S_LD_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sb_adr[r_wr_ptr] <= {bus.i_addr[ADDR_W-1:2], 2'b00};
      r_sb_dat[r_wr_ptr] <= w_wdat;
      r_sb_sel[r_wr_ptr] <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
      r_cyc <= 1'b0; r_stb <= 1'b0; r_we <= 1'b0;
      r_adr <= '0; r_dat <= '0; r_sel <= '0; r_wdog <= '0;
      r_ld_size <= '0; r_ld_off <= '0; r_ld_uns <= 1'b0; r_ld_err <= 1'b0; r_ld_data <= '0;
      r_valid <= 1'b0; r_err <= 1'b0; r_data <= '0; r_store_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
      r_store_err <= 1'b0;
      if (w_acc && w_misalign) begin
        r_valid <= 1'b1;
        r_err   <= 1'b1;
      end else if (w_push) begin
        r_valid <= 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PW'(1);
        r_store_err <= !bus.i_wb_ack;
      end
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= 1'b1;
            r_adr <= r_sb_adr[r_rd_ptr];
            r_dat <= r_sb_dat[r_rd_ptr];
            r_sel <= r_sb_sel[r_rd_ptr];
            r_wdog <= WD_INIT;
          end else if (w_ld_go) begin
            r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= 1'b0;
            r_adr <= {bus.i_addr[ADDR_W-1:2], 2'b00};
            r_dat <= '0;
            r_sel <= w_sel;
            r_wdog <= WD_INIT;
            r_ld_size <= bus.i_size;
            r_ld_off  <= bus.i_addr[1:0];
            r_ld_uns  <= bus.i_unsigned;
          end
        end
        S_ST_BUS, S_LD_BUS: begin
          if (w_done) begin
            r_cyc <= 1'b0; r_stb <= 1'b0; r_we <= 1'b0;
            if (r_state == S_LD_BUS) begin
              r_ld_err  <= !bus.i_wb_ack;
              r_ld_data <= w_ld_ext;
            end
          end else if (r_wdog != '0) begin
            r_wdog <= r_wdog - WD_W'(1);
          end
        end
        default: begin
          r_valid <= 1'b1;
          r_err   <= r_ld_err;
          r_data  <= r_ld_err ? 32'h0 : r_ld_data;
        end
      endcase
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_valid     = r_valid;
  assign bus.o_data      = r_data;
  assign bus.o_err       = r_err;
  assign bus.o_store_err = r_store_err;
  assign bus.o_sb_empty  = (r_count == '0) && (r_state != S_ST_BUS);
  assign bus.o_wb_adr    = r_adr;
  assign bus.o_wb_dat    = r_dat;
  assign bus.o_wb_sel    = r_sel;
  assign bus.o_wb_we     = r_we;
  assign bus.o_wb_cyc    = r_cyc;
  assign bus.o_wb_stb    = r_stb;
endmodule

// File: tb/tb_lsu_sbuf.sv
// Bench for lsu_sbuf: program-order memory model, Wishbone slave with bus-order scoreboard,
// completion monitor, directed corner cases followed by randomized traffic.
module tb_lsu_sbuf;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  lsu_sbuf_if #(.ADDR_W(32)) bif ();
  lsu_sbuf #(.ADDR_W(32), .SB_DEPTH(4), .TIMEOUT(8)) dut (.clk(clk), .rst_i(rst_i), .bus(bif));

  typedef struct {bit is_ld; bit err; logic [31:0] data;} exp_t;
  typedef struct {bit we; logic [31:0] adr; logic [3:0] sel; logic [31:0] dat;} bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] smem [64];
  logic [31:0] mmem [64];
  int          n_total = 0, n_pass = 0;
  int          serr_exp = 0, serr_obs = 0;
  bit          hold = 1'b0;
  int          fixed_w = -1;
  bit          acc_sb_empty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s: event not expected / bound expired at %0t", name, $time);
  endtask

  // Wishbone slave: pops the next expected bus transaction when a cycle starts.
  bit   s_active = 1'b0;
  int   s_wcnt = 0;
  bus_t s_b;
  initial begin
    bif.i_wb_ack = 1'b0; bif.i_wb_err = 1'b0; bif.i_wb_dat = '0;
  end
  always begin
    @(posedge clk); #1;
    bif.i_wb_ack = 1'b0;
    bif.i_wb_err = 1'b0;
    bif.i_wb_dat = $urandom;
    if (!bif.o_wb_cyc) s_active = 1'b0;
    else if (bif.o_wb_stb) begin
      if (!s_active) begin
        s_active = 1'b1;
        s_wcnt = (fixed_w >= 0) ? fixed_w : int'($urandom_range(0, 3));
        if (bus_q.size() == 0) note_fail("bus_unexpected_cycle");
        else begin
          s_b = bus_q.pop_front();
          chk("bus_we", bif.o_wb_we, s_b.we);
          chk("bus_adr", bif.o_wb_adr, s_b.adr);
          chk("bus_sel", bif.o_wb_sel, s_b.sel);
          if (s_b.we) chk("bus_dat", bif.o_wb_dat, s_b.dat);
        end
      end
      if (!hold) begin
        if (s_wcnt == 0) begin
          if (bif.o_wb_adr[7:4] == 4'hF) bif.i_wb_err = 1'b1;
          else begin
            bif.i_wb_ack = 1'b1;
            if (bif.o_wb_we) begin
              for (int l = 0; l < 4; l++)
                if (bif.o_wb_sel[l]) smem[bif.o_wb_adr[7:2]][8*l +: 8] = bif.o_wb_dat[8*l +: 8];
            end else bif.i_wb_dat = smem[bif.o_wb_adr[7:2]];
          end
        end else s_wcnt--;
      end
    end
  end

  exp_t m_e;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (bif.o_store_err) serr_obs++;
      if (bif.o_valid) begin
        if (exp_q.size() == 0) note_fail("valid_unexpected");
        else begin
          m_e = exp_q.pop_front();
          chk("cmpl_err", bif.o_err, m_e.err);
          if (m_e.is_ld) chk("ld_data", bif.o_data, m_e.data);
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] sz, input bit un,
                       input logic [31:0] ad, input logic [31:0] dt, output int waited);
    exp_t e;
    bus_t b;
    int off, idx, nb;
    logic [31:0] mask, v;
    bif.i_req = 1'b1; bif.i_we = we; bif.i_size = sz; bif.i_unsigned = un;
    bif.i_addr = ad; bif.i_data = dt;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (bif.o_ready) break;
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        note_fail("issue_stall");
        bif.i_req = 1'b0;
        return;
      end
    end
    acc_sb_empty = bif.o_sb_empty;
    off = int'(ad[1:0]);
    idx = int'(ad[7:2]);
    nb  = (sz == 2'd3) ? 0 : (1 << sz);
    e.is_ld = !we; e.err = 1'b0; e.data = '0;
    if (nb == 0 || (off % nb) != 0) e.err = 1'b1;
    else begin
      b.we  = we;
      b.adr = {ad[31:2], 2'b00};
      b.sel = 4'(((1 << nb) - 1) << off);
      b.dat = (nb == 1) ? (dt & 32'hFF) * 32'h0101_0101 :
              (nb == 2) ? (dt & 32'hFFFF) * 32'h0001_0001 : dt;
      bus_q.push_back(b);
      if (we) begin
        if (ad[7:4] == 4'hF) serr_exp++;
        else for (int i = 0; i < nb; i++) mmem[idx][8*(off+i) +: 8] = dt[8*i +: 8];
      end else if (ad[7:4] == 4'hF || hold) e.err = 1'b1;
      else begin
        mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8*nb)) - 32'h1;
        v = (mmem[idx] >> (8*off)) & mask;
        if (!un && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.data = v;
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    bif.i_req = 1'b0;
    bif.i_addr = $urandom;
    bif.i_data = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(bif.o_sb_empty && !bif.o_wb_cyc)) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin note_fail(name); return; end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string name);
    int n = 0;
    while (!bif.o_wb_cyc) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin note_fail(name); return; end
    end
  endtask

  initial begin
    int w, n;
    bif.i_req = 1'b0; bif.i_we = 1'b1; bif.i_size = '0; bif.i_unsigned = 1'b0;
    bif.i_addr = '0; bif.i_data = '0;
    for (int i = 0; i < 64; i++) begin smem[i] = $urandom; mmem[i] = smem[i]; end

    bif.i_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bif.o_ready, 0);
    chk("rst_cyc", bif.o_wb_cyc, 0);
    chk("rst_valid", bif.o_valid, 0);
    chk("rst_sb_empty", bif.o_sb_empty, 1);
    @(posedge clk); #1;
    rst_i = 1'b0; bif.i_req = 1'b0;
    @(negedge clk);
    chk("post_rst_store_ready", bif.o_ready, 1);
    @(posedge clk); #1;

    // posted byte store
    fixed_w = 0;
    issue(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, w);
    chk("st_valid_t1", bif.o_valid, 1);
    chk("st_err_t1", bif.o_err, 0);
    wait_cyc("st_no_cyc");
    chk("st_adr", bif.o_wb_adr, 32'h1000);
    chk("st_sel", bif.o_wb_sel, 4'b1000);
    chk("st_dat", bif.o_wb_dat, 32'hA5A5_A5A5);
    wait_idle("st_drain");

    // signed half load with two wait states
    smem[0] = 32'h8001_1234; mmem[0] = 32'h8001_1234;
    fixed_w = 2;
    issue(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, w);
    chk("ld_stb_t1", bif.o_wb_stb, 1);
    chk("ld_adr", bif.o_wb_adr, 32'h2000);
    chk("ld_sel", bif.o_wb_sel, 4'b1100);
    n = 0;
    while (!bif.o_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("ld_latency", n, 4);
    chk("ld_data_dir", bif.o_data, 32'hFFFF_8001);
    wait_idle("ld_done");

    // fill the buffer while the slave stalls
    fixed_w = 0; hold = 1'b1;
    for (int k = 0; k < 4; k++) issue(1'b1, 2'd2, 1'b0, 32'h40 + 32'(4*k), $urandom, w);
    bif.i_we = 1'b1;
    repeat (3) begin @(negedge clk); chk("full_ready", bif.o_ready, 0); end
    @(posedge clk); hold = 1'b0; #1;
    issue(1'b1, 2'd2, 1'b0, 32'h50, $urandom, w);
    chk("full_push_pop_wait", w, 0);
    wait_idle("full_drain");

    // load right behind a store
    fixed_w = 1;
    issue(1'b1, 2'd2, 1'b0, 32'h10, $urandom, w);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, w);
    chk("ld_after_st_empty", acc_sb_empty, 1);
    chk("ld_after_st_waited", w > 0, 1);
    wait_idle("ld_after_st");

    // misaligned word load
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, w);
    chk("mis_valid", bif.o_valid, 1);
    chk("mis_err", bif.o_err, 1);
    chk("mis_data", bif.o_data, 0);
    chk("mis_no_cyc", bif.o_wb_cyc, 0);
    wait_idle("mis_done");

    // load watchdog
    hold = 1'b1;
    issue(1'b0, 2'd2, 1'b1, 32'h30, 32'h0, w);
    n = 0;
    while (bif.o_wb_stb && n < 50) begin n++; @(posedge clk); #1; end
    chk("to_stb_cycles", n, 8);
    @(posedge clk); #1;
    chk("to_valid", bif.o_valid, 1);
    chk("to_err", bif.o_err, 1);
    hold = 1'b0;
    wait_idle("to_done");

    // randomized traffic
    fixed_w = -1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(1'($urandom), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            1'($urandom), 32'($urandom_range(0, 255)), $urandom, w);
    end
    wait_idle("rand_drain");

    // reset in the middle of a store
    hold = 1'b1; fixed_w = 0;
    issue(1'b1, 2'd2, 1'b0, 32'h20, $urandom, w);
    wait_cyc("rst_mid_no_cyc");
    rst_i = 1'b1; bif.i_we = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", bif.o_ready, 0);
    @(posedge clk); #1;
    chk("rst_mid_cyc", bif.o_wb_cyc, 0);
    chk("rst_mid_stb", bif.o_wb_stb, 0);
    chk("rst_mid_sb_empty", bif.o_sb_empty, 1);
    rst_i = 1'b0; hold = 1'b0; fixed_w = -1;
    exp_q.delete(); bus_q.delete();
    for (int i = 0; i < 64; i++) mmem[i] = smem[i];
    for (int i = 0; i < 20; i++)
      issue(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
            32'($urandom_range(0, 255)) & 32'hFC, $urandom, w);
    wait_idle("post_rst_drain");

    chk("exp_q_empty", exp_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("store_err_count", serr_obs, serr_exp);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule
